// File: rtl/state_ctrl_param.sv
// rtl/state_ctrl_param.sv - implication settle detector, conflict-analysis FSM and backtrack level tracker
module state_ctrl_param #(
    parameter int NUM_VARS        = 8,
    parameter int NUM_LVLS        = 8,
    parameter int WIDTH_LVL       = 16,
    parameter int SETTLE_CYCLES   = 1,
    parameter int ANALYZE_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_VARS-1:0]  find_imply_i,
    input  logic [NUM_VARS-1:0]  find_conflict_i,
    input  logic                 apply_imply_i,
    output logic                 done_imply_o,
    output logic                 find_conflict_o,
    input  logic                 apply_analyze_i,
    output logic                 add_learntc_en_o,
    output logic                 done_analyze_o,
    output logic                 analyze_timeout_o,
    input  logic [NUM_LVLS-1:0]  findindex_i,
    input  logic [WIDTH_LVL-1:0] max_lvl_i,
    input  logic                 base_lvl_en,
    input  logic [WIDTH_LVL-1:0] base_lvl_i,
    output logic [WIDTH_LVL-1:0] base_lvl_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic                 bkt_inter_bin_o,
    input  logic                 apply_bkt_i,
    output logic                 done_bkt_o
);

    localparam int LW = $clog2(NUM_LVLS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIND = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Implication settle detector
    // ------------------------------------------------------------------
    logic [NUM_VARS-1:0] r_find_imply_pre;
    logic [3:0]          r_stable_cnt;
    logic                r_done_imply;
    logic                w_stable;
    logic                w_settled;
    logic                w_imply_conflict;

    assign w_stable         = apply_imply_i && (find_imply_i == r_find_imply_pre);
    assign w_settled        = (r_stable_cnt == 4'(SETTLE_CYCLES));
    assign w_imply_conflict = apply_imply_i && (|find_conflict_i);
    assign find_conflict_o  = |find_conflict_i;

    // The counter clears on the cycle it fires so a held-stable vector re-arms the detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_find_imply_pre <= '0;
            r_stable_cnt     <= '0;
            r_done_imply     <= 1'b0;
        end else begin
            r_find_imply_pre <= find_imply_i;
            if (w_settled)
                r_stable_cnt <= '0;
            else if (w_stable)
                r_stable_cnt <= r_stable_cnt + 4'd1;
            else
                r_stable_cnt <= '0;
            r_done_imply <= w_settled || w_imply_conflict;
        end
    end

    assign done_imply_o = r_done_imply;

    // ------------------------------------------------------------------
    // Conflict-analysis FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [NUM_VARS-1:0] r_conflict_d;
    logic [7:0]  r_to_cnt;
    logic        w_conflict_chg;
    logic        w_to_hit;
    logic        w_add_nxt;
    logic        w_done_nxt;
    logic        w_to_nxt;
    logic        r_add;
    logic        r_done_ana;
    logic        r_to;

    assign w_conflict_chg = (find_conflict_i != r_conflict_d);
    // Leaving on the cycle the count would reach the limit bounds FIND to ANALYZE_TIMEOUT cycles.
    assign w_to_hit       = (r_to_cnt == 8'(ANALYZE_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (apply_bkt_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (apply_analyze_i) w_state_nxt = S_FIND;
                S_FIND: begin
                    if (w_conflict_chg)
                        w_state_nxt = S_ADD;
                    else if (w_to_hit)
                        w_state_nxt = S_DONE;
                end
                S_ADD:   w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A backtrack request suppresses any analysis pulse that would otherwise be registered.
    always_comb begin
        w_add_nxt  = 1'b0;
        w_done_nxt = 1'b0;
        w_to_nxt   = 1'b0;
        if (!apply_bkt_i) begin
            w_add_nxt  = (r_state == S_ADD);
            w_done_nxt = (r_state == S_DONE);
            w_to_nxt   = (r_state == S_FIND) && !w_conflict_chg && w_to_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_d <= '0;
            r_to_cnt     <= '0;
            r_add        <= 1'b0;
            r_done_ana   <= 1'b0;
            r_to         <= 1'b0;
        end else begin
            r_conflict_d <= find_conflict_i;
            if (r_state == S_FIND)
                r_to_cnt <= r_to_cnt + 8'd1;
            else
                r_to_cnt <= '0;
            r_add      <= w_add_nxt;
            r_done_ana <= w_done_nxt;
            r_to       <= w_to_nxt;
        end
    end

    assign add_learntc_en_o  = r_add;
    assign done_analyze_o    = r_done_ana;
    assign analyze_timeout_o = r_to;

    // ------------------------------------------------------------------
    // Backtrack level tracking
    // ------------------------------------------------------------------
    logic [LW-1:0]        w_local_bkt;
    logic                 w_no_local;
    logic [WIDTH_LVL-1:0] r_base;
    logic [WIDTH_LVL-1:0] r_bkt;
    logic                 r_inter;
    logic                 r_done_bkt;

    always_comb begin
        w_local_bkt = '0;
        for (int i = 0; i < NUM_LVLS; i++) begin
            if (findindex_i[i])
                w_local_bkt = LW'(i);
        end
    end

    assign w_no_local = (findindex_i == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_bkt      <= '0;
            r_inter    <= 1'b0;
            r_done_bkt <= 1'b0;
        end else begin
            if (base_lvl_en)
                r_base <= base_lvl_i;
            r_bkt      <= w_no_local ? max_lvl_i : (r_base + WIDTH_LVL'(w_local_bkt));
            r_inter    <= w_no_local;
            r_done_bkt <= apply_bkt_i;
        end
    end

    assign base_lvl_o      = r_base;
    assign bkt_lvl_o       = r_bkt;
    assign bkt_inter_bin_o = r_inter;
    assign done_bkt_o      = r_done_bkt;

endmodule

// File: tb/tb_state_ctrl_param.sv
// tb/tb_state_ctrl_param.sv - randomized self-checking bench for state_ctrl_param
module tb_state_ctrl_param;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WL = 16;
    localparam int SC = 2;
    localparam int AT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NV-1:0] find_imply_i, find_conflict_i;
    logic          apply_imply_i, apply_analyze_i, base_lvl_en, apply_bkt_i;
    logic [NL-1:0] findindex_i;
    logic [WL-1:0] max_lvl_i, base_lvl_i;
    logic          done_imply_o, find_conflict_o, add_learntc_en_o, done_analyze_o;
    logic          analyze_timeout_o, bkt_inter_bin_o, done_bkt_o;
    logic [WL-1:0] base_lvl_o, bkt_lvl_o;

    state_ctrl_param #(
        .NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
        .SETTLE_CYCLES(SC), .ANALYZE_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst(rst),
        .find_imply_i(find_imply_i), .find_conflict_i(find_conflict_i),
        .apply_imply_i(apply_imply_i), .done_imply_o(done_imply_o),
        .find_conflict_o(find_conflict_o), .apply_analyze_i(apply_analyze_i),
        .add_learntc_en_o(add_learntc_en_o), .done_analyze_o(done_analyze_o),
        .analyze_timeout_o(analyze_timeout_o), .findindex_i(findindex_i),
        .max_lvl_i(max_lvl_i), .base_lvl_en(base_lvl_en), .base_lvl_i(base_lvl_i),
        .base_lvl_o(base_lvl_o), .bkt_lvl_o(bkt_lvl_o),
        .bkt_inter_bin_o(bkt_inter_bin_o), .apply_bkt_i(apply_bkt_i),
        .done_bkt_o(done_bkt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycle index, history of last inputs, and scheduled output pulses.
    int            cyc;
    logic [NV-1:0] m_imp_prev, m_cf_prev;
    int            m_cnt;
    logic [WL-1:0] m_base;
    bit            m_in_find;
    int            m_age, m_idle_from, m_add_at, m_done_at, m_to_at;
    logic          e_done_imp, e_add, e_done_ana, e_to, e_inter, e_done_bkt;
    logic [WL-1:0] e_bkt, e_base;

    function automatic int msb_idx(input logic [NL-1:0] v);
        for (int i = NL - 1; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_imp_prev = '0; m_cf_prev = '0; m_cnt = 0; m_base = '0;
        m_in_find = 1'b0; m_age = 0; m_idle_from = 0;
        m_add_at = -1; m_done_at = -1; m_to_at = -1;
    endtask

    task automatic model_update();
        bit hit, eq, chg;
        e_done_bkt = apply_bkt_i;
        e_inter    = (findindex_i == 0);
        e_bkt      = e_inter ? max_lvl_i : WL'(int'(m_base) + msb_idx(findindex_i));
        if (base_lvl_en) m_base = base_lvl_i;
        e_base     = m_base;

        hit        = (m_cnt == SC);
        eq         = (find_imply_i == m_imp_prev);
        e_done_imp = hit || (apply_imply_i && find_conflict_i != 0);
        if (hit) m_cnt = 0;
        else if (apply_imply_i && eq) m_cnt++;
        else m_cnt = 0;
        m_imp_prev = find_imply_i;

        chg       = (find_conflict_i != m_cf_prev);
        m_cf_prev = find_conflict_i;
        if (apply_bkt_i) begin
            m_in_find = 1'b0; m_add_at = -1; m_done_at = -1; m_to_at = -1;
            m_idle_from = cyc + 1;
        end else if (m_in_find) begin
            if (chg) begin
                m_add_at = cyc + 1; m_done_at = cyc + 2; m_idle_from = cyc + 3; m_in_find = 1'b0;
            end else if (m_age == AT - 1) begin
                m_to_at = cyc; m_done_at = cyc + 1; m_idle_from = cyc + 2; m_in_find = 1'b0;
            end else begin
                m_age++;
            end
        end else if (cyc >= m_idle_from && apply_analyze_i) begin
            m_in_find = 1'b1; m_age = 0;
        end
        e_add      = (m_add_at == cyc);
        e_done_ana = (m_done_at == cyc);
        e_to       = (m_to_at == cyc);
    endtask

    task automatic step();
        #1 chk("find_conflict_o", find_conflict_o, find_conflict_i != 0);
        @(posedge clk);
        model_update();
        #1;
        chk("done_imply_o", done_imply_o, e_done_imp);
        chk("add_learntc_en_o", add_learntc_en_o, e_add);
        chk("done_analyze_o", done_analyze_o, e_done_ana);
        chk("analyze_timeout_o", analyze_timeout_o, e_to);
        chk("base_lvl_o", base_lvl_o, e_base);
        chk("bkt_lvl_o", bkt_lvl_o, e_bkt);
        chk("bkt_inter_bin_o", bkt_inter_bin_o, e_inter);
        chk("done_bkt_o", done_bkt_o, e_done_bkt);
        cyc++;
    endtask

    task automatic zero_inputs();
        find_imply_i = '0; find_conflict_i = '0; apply_imply_i = 1'b0;
        apply_analyze_i = 1'b0; base_lvl_en = 1'b0; apply_bkt_i = 1'b0;
        findindex_i = '0; max_lvl_i = '0; base_lvl_i = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        zero_inputs();
        #2;
        chk("rst_done_imply", done_imply_o, 0);
        chk("rst_add", add_learntc_en_o, 0);
        chk("rst_done_ana", done_analyze_o, 0);
        chk("rst_timeout", analyze_timeout_o, 0);
        chk("rst_base", base_lvl_o, 0);
        chk("rst_bkt", bkt_lvl_o, 0);
        chk("rst_inter", bkt_inter_bin_o, 0);
        chk("rst_done_bkt", done_bkt_o, 0);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    int n_add, n_done, n_to, n_imp;

    task automatic clr_counts();
        n_add = 0; n_done = 0; n_to = 0; n_imp = 0;
    endtask

    task automatic tally();
        n_add  += int'(add_learntc_en_o);
        n_done += int'(done_analyze_o);
        n_to   += int'(analyze_timeout_o);
        n_imp  += int'(done_imply_o);
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        cyc = 0;
        model_reset();
        #3;
        do_reset(2);

        // Settle with constant vector 8'h05.
        clr_counts();
        apply_imply_i = 1'b1; find_imply_i = 8'h05;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) apply_imply_i = 1'b0;
            step();
            tally();
            if (i == 3) chk("settle_pulse_at_3", done_imply_o, 1);
        end
        chk("settle_once", n_imp, 1);

        // Conflict forces implication done on next cycle.
        apply_imply_i = 1'b1; find_conflict_i = 8'h10;
        #1 chk("conflict_comb", find_conflict_o, 1);
        step();
        chk("conflict_done_imply", done_imply_o, 1);
        apply_imply_i = 1'b0; find_conflict_i = '0;
        step(); step();

        // Analysis: conflict changes 3 cycles after start.
        apply_analyze_i = 1'b1; step();
        apply_analyze_i = 1'b0; step(); step();
        find_conflict_i = 8'h01; step();
        chk("ana_add_early", add_learntc_en_o, 0);
        step();
        chk("ana_add", add_learntc_en_o, 1);
        chk("ana_done_early", done_analyze_o, 0);
        step();
        chk("ana_done", done_analyze_o, 1);
        chk("ana_add_once", add_learntc_en_o, 0);

        // Analysis timeout with static conflict vector.
        clr_counts();
        apply_analyze_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            apply_analyze_i = 1'b0;
            tally();
            if (j == 4) chk("to_pulse", analyze_timeout_o, 1);
            if (j == 5) chk("to_done", done_analyze_o, 1);
        end
        chk("to_count", n_to, 1);
        chk("to_done_count", n_done, 1);
        chk("to_no_add", n_add, 0);

        // Backtrack levels.
        base_lvl_en = 1'b1; base_lvl_i = 16'd20; step();
        base_lvl_en = 1'b0; findindex_i = 8'b0010_0100; step();
        chk("bkt_local", bkt_lvl_o, 25);
        chk("bkt_local_inter", bkt_inter_bin_o, 0);
        findindex_i = '0; max_lvl_i = 16'd7; step();
        chk("bkt_max", bkt_lvl_o, 7);
        chk("bkt_inter", bkt_inter_bin_o, 1);

        // Backtrack aborts analysis in FIND.
        find_conflict_i = 8'h01;
        apply_analyze_i = 1'b1; step();
        apply_analyze_i = 1'b0; step();
        apply_bkt_i = 1'b1; step();
        chk("bkt_ack", done_bkt_o, 1);
        apply_bkt_i = 1'b0;
        clr_counts();
        find_conflict_i = 8'h22;
        for (int j = 0; j < 6; j++) begin
            step();
            tally();
            if (j == 0) chk("bkt_ack_drop", done_bkt_o, 0);
        end
        chk("bkt_no_add", n_add, 0);
        chk("bkt_no_done", n_done + n_to, 0);

        // Reset mid-analysis and mid-settle.
        apply_analyze_i = 1'b1; step();
        apply_analyze_i = 1'b0; step();
        find_conflict_i = 8'h40; step();
        do_reset(2);
        clr_counts();
        for (int j = 0; j < 6; j++) begin step(); tally(); end
        chk("rst_ana_no_pulse", n_add + n_done + n_to, 0);
        apply_imply_i = 1'b1; find_imply_i = 8'h0A; step(); step();
        do_reset(1);
        clr_counts();
        for (int j = 0; j < 6; j++) begin step(); tally(); end
        chk("rst_settle_no_pulse", n_imp, 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 10) apply_imply_i = ~apply_imply_i;
            if ($urandom_range(99) < 15) find_imply_i = NV'($urandom);
            if ($urandom_range(99) < 8)
                find_conflict_i = ($urandom_range(1) == 0) ? '0 : NV'($urandom);
            apply_analyze_i = ($urandom_range(99) < 15);
            apply_bkt_i     = ($urandom_range(99) < 4);
            base_lvl_en     = ($urandom_range(99) < 10);
            base_lvl_i      = WL'($urandom);
            findindex_i     = ($urandom_range(99) < 30) ? '0 : NL'($urandom);
            max_lvl_i       = WL'($urandom);
            if ($urandom_range(999) < 3) do_reset($urandom_range(1, 3));
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
